// File: rtl/fifo_axis_pkg.sv
// Shared constants for the async-FIFO read-side AXI-Stream drain engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_axis_pkg;

  // Default FIFO word / stream data width.
  localparam int DATA_W_DEF = 16;

  // Default packet-length / beat-counter width; a length of 0 means 2**LEN_W beats.
  localparam int LEN_W_DEF = 8;

  // Skid-buffer occupancy counter width (holds 0, 1 or 2).
  localparam int OCC_W = 2;

  // Occupancy value at which the skid buffer can accept nothing more.
  localparam logic [OCC_W-1:0] OCC_FULL = 2'd2;

  // True when the skid buffer has room for another word.
  function automatic logic occ_has_room(input logic [OCC_W-1:0] occ);
    return (occ < OCC_FULL);
  endfunction

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry skid buffer: entry 0 is always the head presented downstream.
// Latency: a word pushed into an empty buffer is visible at head_data the next cycle.
// Backpressure: occupancy is exported; the owner must stop pushing when occ==2.
//
// Ports:
//   clk, resetn      clock and async active-low reset
//   push, push_data  write a word at the tail on this clk edge
//   pop              remove the head word on this clk edge
//   occ              number of valid entries (0..2), registered
//   head_data        oldest entry, registered
module axis_skid_buf2
  import fifo_axis_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;
  logic              push_ok;
  logic              pop_ok;

  // Guard against misuse: never pop an empty buffer, never overfill it.
  assign push_ok   = push && (occ != OCC_FULL);
  assign pop_ok    = pop && (occ != '0);
  assign head_data = ent0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          // Fill the first free slot.
          if (occ == '0) ent0 <= push_data;
          else           ent1 <= push_data;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          // Shift the second entry forward; stale copy in ent1 is harmless.
          ent0 <= ent1;
          occ  <= occ - OCC_W'(1);
        end
        2'b11: begin
          // Push and pop together: occupancy unchanged, streaming 1 word/cycle.
          if (occ == OCC_W'(1)) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains the async FIFO read port into an AXI-Stream master framed into packets of pkt_len beats.
// Latency: FIFO word popped on cycle N appears on m_axis_tdata in cycle N+1 (empty buffer).
// Backpressure: 2-entry skid buffer absorbs tready stalls; rd_en depends only on occupancy, never on tready.
//
// Ports:
//   clk, resetn              read-domain clock, async active-low reset
//   fifo_empty/rd_en/rd_data FIFO read port; rd_data valid in the cycle rd_en is high
//   pkt_len                  beats per packet, sampled while at beat 0 (0 = 2**LEN_W)
//   m_axis_t*                AXI-Stream master (tdata, tvalid, tready, tlast)
//   beat_cnt                 index of the current beat within its packet
//   pkt_done                 one-cycle registered pulse after each tlast handshake
module fifo_axis_reader
  import fifo_axis_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fifo_empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic              pkt_done
);

  logic [OCC_W-1:0] occ;
  logic [LEN_W-1:0] len_q;
  logic             hs;

  // resetn gates the pop combinationally so nothing leaves the FIFO while in reset.
  assign rd_en = resetn && !fifo_empty && occ_has_room(occ);

  assign m_axis_tvalid = (occ != '0);
  assign hs            = m_axis_tvalid && m_axis_tready;

  // Wraps modulo 2**LEN_W, so len_q==0 marks the last beat at index 2**LEN_W-1.
  assign m_axis_tlast = (beat_cnt == (len_q - LEN_W'(1)));

  axis_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rd_en),
    .push_data (rd_data),
    .pop       (hs),
    .occ       (occ),
    .head_data (m_axis_tdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q    <= '0;
      beat_cnt <= '0;
      pkt_done <= 1'b0;
    end else begin
      // Track pkt_len only between packets; frozen once beat 1 is reached.
      if (beat_cnt == '0) begin
        len_q <= pkt_len;
      end
      if (hs) begin
        beat_cnt <= m_axis_tlast ? '0 : (beat_cnt + LEN_W'(1));
      end
      pkt_done <= hs && m_axis_tlast;
    end
  end

endmodule
